// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: well-known register indices, default widths
// and the basic word/register-index types.
package mips_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_V0   = 2;
    localparam int unsigned REG_RA   = 31;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage : mips_pkg

// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: two combinational read ports with optional
// same-cycle write forwarding, one clocked write port, and a direct $v0 tap.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] register_v0
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
    localparam logic [ADDR_WIDTH-1:0] V0_IDX   = ADDR_WIDTH'(REG_V0);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wr_active;

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    // Forwarding is deliberately not gated by reset, so a write strobe is still
    // visible on the read ports while the array is held cleared.
    assign wr_active = write_enable && (write_addr != ZERO_IDX);

    always_comb begin
        regs_d = regs_q;
        if (wr_active) begin
            regs_d[write_addr] = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_addr[0]  = read_addr_a;
    assign rd_addr[1]  = read_addr_b;
    assign read_data_a = rd_data[0];
    assign read_data_b = rd_data[1];

    for (genvar p = 0; p < 2; p++) begin : g_read
        always_comb begin
            rd_data[p] = regs_q[rd_addr[p]];
            if (rd_addr[p] == ZERO_IDX) begin
                rd_data[p] = '0;
            end else if (BYPASS && wr_active && (rd_addr[p] == write_addr)) begin
                rd_data[p] = write_data;
            end
        end
    end

    assign register_v0 = regs_q[V0_IDX];

endmodule : mips_register_file

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: one instance with forwarding, one without.
module tb_mips_register_file;
    import mips_pkg::*;

    typedef struct {
        string name;
        word_t a1, b1, a0, b0, v0;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    reg_addr_t read_addr_a = '0, read_addr_b = '0, write_addr = '0;
    logic      write_enable = 1'b0;
    word_t     write_data = '0;
    word_t     rda1, rdb1, v01, rda0, rdb0, v00;

    exp_t  exp_q[$];
    word_t model[32];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda1), .read_data_b(rdb1),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .register_v0(v01)
    );

    mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_b0 (
        .clk(clk), .rst_n(rst_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda0), .read_data_b(rdb0),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .register_v0(v00)
    );

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: the read ports are combinational, so every negedge presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, " bp1.a"}, rda1, e.a1);
                chk({e.name, " bp1.b"}, rdb1, e.b1);
                chk({e.name, " bp1.v0"}, v01, e.v0);
                chk({e.name, " bp0.a"}, rda0, e.a0);
                chk({e.name, " bp0.b"}, rdb0, e.b0);
                chk({e.name, " bp0.v0"}, v00, e.v0);
            end
        end
    end

    task automatic step(input string nm, input logic rst, input logic we,
                        input reg_addr_t wa, input word_t wd,
                        input reg_addr_t ra, input reg_addr_t rb,
                        input word_t a1, input word_t b1,
                        input word_t a0, input word_t b0, input word_t v0);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr_a  = ra;
        read_addr_b  = rb;
        e.name = nm; e.a1 = a1; e.b1 = b1; e.a0 = a0; e.b0 = b0; e.v0 = v0;
        exp_q.push_back(e);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
    endtask

    function automatic word_t model_read(input reg_addr_t ra, input logic bp,
                                         input logic we, input reg_addr_t wa, input word_t wd);
        if (ra == 5'd0) return '0;
        if (bp && we && wa != 5'd0 && wa == ra) return wd;
        return model[ra];
    endfunction

    initial begin
        reg_addr_t ra, rb, wa;
        word_t     wd;
        logic      we;
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (2) @(posedge clk);

        //   name        rst  we   wa     wd            ra     rb     a1            b1            a0            b0            v0
        step("rst_hold", 0, 0, 5'd0,  32'h0,        5'd8,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        step("wr8",      1, 1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
        step("rd8",      1, 0, 5'd0,  32'h0,        5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
        step("wr0",      1, 1, 5'd0,  32'h12345678, 5'd0,  5'd8,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0);
        step("rd0",      1, 0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        step("wr5a",     1, 1, 5'd5,  32'h11111111, 5'd8,  5'd5,  32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF, 32'h0,        32'h0);
        step("wr5b",     1, 1, 5'd5,  32'h22222222, 5'd5,  5'd0,  32'h22222222, 32'h0,        32'h11111111, 32'h0,        32'h0);
        step("rd5",      1, 0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, 32'h0);
        step("wrv0",     1, 1, 5'd2,  32'h000000FF, 5'd2,  5'd3,  32'h000000FF, 32'h0,        32'h0,        32'h0,        32'h0);
        step("v0_gated", 1, 0, 5'd2,  32'hFFFFFFFF, 5'd2,  5'd8,  32'h000000FF, 32'hDEADBEEF, 32'h000000FF, 32'hDEADBEEF, 32'h000000FF);
        step("v0_hold",  1, 0, 5'd0,  32'h0,        5'd2,  5'd5,  32'h000000FF, 32'h22222222, 32'h000000FF, 32'h22222222, 32'h000000FF);
        step("wr31_ab",  1, 1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h000000FF);
        step("rst_mid",  0, 0, 5'd0,  32'h0,        5'd8,  5'd2,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0);
        step("rst_fwd",  0, 1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd0,  32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        32'h0);
        step("rst_rel",  1, 0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0);

        for (int it = 0; it < 50; it++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            if (it % 10 == 0) ra = 5'd0;
            step($sformatf("rnd%0d", it), 1, we, wa, wd, ra, rb,
                 model_read(ra, 1'b1, we, wa, wd), model_read(rb, 1'b1, we, wa, wd),
                 model_read(ra, 1'b0, we, wa, wd), model_read(rb, 1'b0, we, wa, wd),
                 model[2]);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mips_register_file
